// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles both requester ports, the response port and the ALU side.
// Latency: none (wiring only).
// Backpressure: carries valid/ready on each request port and on the response port.
interface alu_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int CID_W = 10
);
  logic             req0_valid_in;
  logic             req0_ready_out;
  logic [CID_W-1:0] req0_cid_in;
  logic [XLEN-1:0]  req0_arg1_in;
  logic [XLEN-1:0]  req0_arg2_in;

  logic             req1_valid_in;
  logic             req1_ready_out;
  logic [CID_W-1:0] req1_cid_in;
  logic [XLEN-1:0]  req1_arg1_in;
  logic [XLEN-1:0]  req1_arg2_in;

  logic             rsp_valid_out;
  logic             rsp_ready_in;
  logic             rsp_id_out;
  logic [XLEN-1:0]  rsp_data_out;

  logic [CID_W-1:0] alu_cid_out;
  logic [XLEN-1:0]  alu_arg1_out;
  logic [XLEN-1:0]  alu_arg2_out;
  logic [XLEN-1:0]  alu_arg_in;

  // Arbiter side
  modport slave (
    input  req0_valid_in, req0_cid_in, req0_arg1_in, req0_arg2_in,
    output req0_ready_out,
    input  req1_valid_in, req1_cid_in, req1_arg1_in, req1_arg2_in,
    output req1_ready_out,
    output rsp_valid_out, rsp_id_out, rsp_data_out,
    input  rsp_ready_in,
    output alu_cid_out, alu_arg1_out, alu_arg2_out,
    input  alu_arg_in
  );

  // Requester / consumer / ALU side
  modport master (
    output req0_valid_in, req0_cid_in, req0_arg1_in, req0_arg2_in,
    input  req0_ready_out,
    output req1_valid_in, req1_cid_in, req1_arg1_in, req1_arg2_in,
    input  req1_ready_out,
    input  rsp_valid_out, rsp_id_out, rsp_data_out,
    output rsp_ready_in,
    input  alu_cid_out, alu_arg1_out, alu_arg2_out,
    output alu_arg_in
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between execute (port 0) and address gen (port 1).
// Latency: accept at edge N, rsp_valid after edge N+1; 3 cycles per op with rsp_ready held high.
// Backpressure: holds the result until rsp_ready_in; no new grant while a result is pending.
// Option ALU_ARB_RR_EN: round-robin arbitration; default is port-0 priority with starvation escape.
module alu_arbiter #(
  parameter int XLEN         = 32,
  parameter int CID_W        = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          nrst,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             op_id_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [XLEN-1:0]  rsp_data_q;
  logic [CID_W-1:0] alu_cid_q;
  logic [XLEN-1:0]  alu_arg1_q;
  logic [XLEN-1:0]  alu_arg2_q;

  logic grant_vld;
  logic grant_id;
  logic contended;
  logic idle_ok;

`ifdef ALU_ARB_RR_EN
  logic rr_ptr;
`else
  logic [3:0] starve_cnt;
`endif

  // Pick the port to serve next from the current valids and arbitration state
  always_comb begin
    contended = bus.req0_valid_in & bus.req1_valid_in;
    grant_vld = bus.req0_valid_in | bus.req1_valid_in;
    grant_id  = 1'b0;
    if (contended) begin
`ifdef ALU_ARB_RR_EN
      grant_id = rr_ptr;
`else
      grant_id = (starve_cnt >= 4'(STARVE_LIMIT));
`endif
    end else begin
      grant_id = ~bus.req0_valid_in & bus.req1_valid_in;
    end
  end

  // Ready only while idle and out of reset, and only to the granted port
  assign idle_ok            = (state == IDLE) & nrst & grant_vld;
  assign bus.req0_ready_out = idle_ok & ~grant_id;
  assign bus.req1_ready_out = idle_ok &  grant_id;

  assign bus.rsp_valid_out = rsp_valid_q;
  assign bus.rsp_id_out    = rsp_id_q;
  assign bus.rsp_data_out  = rsp_data_q;
  assign bus.alu_cid_out   = alu_cid_q;
  assign bus.alu_arg1_out  = alu_arg1_q;
  assign bus.alu_arg2_out  = alu_arg2_q;

  // Accept -> drive ALU from registers -> capture result -> hand it off
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      op_id_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      alu_cid_q   <= '0;
      alu_arg1_q  <= '0;
      alu_arg2_q  <= '0;
`ifdef ALU_ARB_RR_EN
      rr_ptr      <= 1'b0;
`else
      starve_cnt  <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            // ALU operands come straight from these registers, so they
            // also hold the last op while idle.
            alu_cid_q  <= grant_id ? bus.req1_cid_in  : bus.req0_cid_in;
            alu_arg1_q <= grant_id ? bus.req1_arg1_in : bus.req0_arg1_in;
            alu_arg2_q <= grant_id ? bus.req1_arg2_in : bus.req0_arg2_in;
            op_id_q    <= grant_id;
            state      <= EXEC;
`ifdef ALU_ARB_RR_EN
            if (contended) rr_ptr <= ~grant_id;
`else
            if (grant_id) begin
              starve_cnt <= 4'd0;
            end else if (bus.req1_valid_in && starve_cnt != 4'hF) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
`endif
          end
        end
        EXEC: begin
          rsp_data_q  <= bus.alu_arg_in;
          rsp_id_q    <= op_id_q;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready_in) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
